// File: rtl/lcd_result_writer_if.sv
`default_nettype none
// ============================================================================
// lcd_result_writer_if : request side and LCD pin bundle for lcd_result_writer
// Rev 1.0
// ============================================================================
interface lcd_result_writer_if;
   logic        start;
   logic [2:0]  opcode;
   logic [15:0] result;
   logic        busy;
   logic [7:0]  lcd_data;
   logic        lcd_rs;
   logic        lcd_rw;
   logic        lcd_e;

   modport master (
      output start, opcode, result,
      input  busy, lcd_data, lcd_rs, lcd_rw, lcd_e
   );

   modport slave (
      input  start, opcode, result,
      output busy, lcd_data, lcd_rs, lcd_rw, lcd_e
   );
endinterface
`default_nettype wire

// File: rtl/lcd_result_writer.sv
`default_nettype none
// ============================================================================
// lcd_result_writer : HD44780 init + "mnemonic / decimal result" display writer
// Optional build macro: LCD_SIGNED_EN (two's complement result, +/- sign char)
// Rev 1.0
// ============================================================================
module lcd_result_writer #(
   parameter int E_CYCLES     = 12,
   parameter int CMD_WAIT     = 2000,
   parameter int CLEAR_WAIT   = 100000,
   parameter int POWERUP_WAIT = 1000000
) (
   input wire             clk,
   input wire             rst_n,
   lcd_result_writer_if.slave bus
);

   // One shared counter covers every wait and the 17-cycle conversion.
   localparam int MAX_A    = (E_CYCLES > CMD_WAIT) ? E_CYCLES : CMD_WAIT;
   localparam int MAX_B    = (MAX_A > CLEAR_WAIT) ? MAX_A : CLEAR_WAIT;
   localparam int MAX_C    = (MAX_B > POWERUP_WAIT) ? MAX_B : POWERUP_WAIT;
   localparam int MAX_WAIT = (MAX_C > 17) ? MAX_C : 17;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);

   localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_WAIT - 1);
   localparam logic [CNT_W-1:0] E_LAST    = CNT_W'(E_CYCLES - 1);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_WAIT - 1);
   localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLEAR_WAIT - 1);
   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(16);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      PWR_WAIT = 3'd0,
      INIT     = 3'd1,
      IDLE     = 3'd2,
      CONV     = 3'd3,
      WR_CLR   = 3'd4,
      WR_L1    = 3'd5,
      WR_ADDR  = 3'd6,
      WR_L2    = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      PH_SETUP = 2'd0,
      PH_PULSE = 2'd1,
      PH_WAIT  = 2'd2
   } phase_t;

   state_t            state_q, state_d;
   phase_t            phase_q, phase_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        idx_q, idx_d;
   logic [2:0]        opcode_q, opcode_d;
   logic [15:0]       result_q, result_d;
   logic [15:0]       bin_q, bin_d;
   logic [19:0]       bcd_q, bcd_d;
   logic [7:0]        lcd_data_q, lcd_data_d;
   logic              lcd_rs_q, lcd_rs_d;
   logic              lcd_e_q, lcd_e_d;
   logic [7:0]        sign_char;
   logic [CNT_W-1:0]  wait_last;
   logic              init_mode;
   logic              last_byte;

`ifdef LCD_SIGNED_EN
   logic neg_q, neg_d;
   assign sign_char = neg_q ? 8'h2D : 8'h2B;
`else
   assign sign_char = 8'h20;
`endif

   function automatic logic [7:0] op_char(input logic [2:0] op, input logic [1:0] pos);
      logic [31:0] s;
      case (op)
         3'd0:    s = "LOAD";
         3'd1:    s = "ADD ";
         3'd2:    s = "ADDI";
         3'd3:    s = "SUB ";
         3'd4:    s = "SUBI";
         3'd5:    s = "MUL ";
         3'd6:    s = "CLR ";
         default: s = "DISP";
      endcase
      case (pos)
         2'd0:    op_char = s[31:24];
         2'd1:    op_char = s[23:16];
         2'd2:    op_char = s[15:8];
         default: op_char = s[7:0];
      endcase
   endfunction

   // Returns {rs, data} for byte idx of either the init or the request stream.
   function automatic logic [8:0] byte_for(input logic       init,
                                           input logic [3:0] idx,
                                           input logic [2:0] op,
                                           input logic [19:0] bcd,
                                           input logic [7:0] sgn);
      logic [8:0] b;
      if (init) begin
         case (idx)
            4'd0:    b = 9'h038;
            4'd1:    b = 9'h00C;
            4'd2:    b = 9'h006;
            default: b = 9'h001;
         endcase
      end else begin
         case (idx)
            4'd0:    b = 9'h001;
            4'd1, 4'd2, 4'd3, 4'd4:
                     b = {1'b1, op_char(op, 2'(idx - 4'd1))};
            4'd5:    b = 9'h0C0;
            4'd6:    b = {1'b1, sgn};
            4'd7:    b = {1'b1, 4'h3, bcd[19:16]};
            4'd8:    b = {1'b1, 4'h3, bcd[15:12]};
            4'd9:    b = {1'b1, 4'h3, bcd[11:8]};
            4'd10:   b = {1'b1, 4'h3, bcd[7:4]};
            default: b = {1'b1, 4'h3, bcd[3:0]};
         endcase
      end
      byte_for = b;
   endfunction

   function automatic state_t req_state(input logic [3:0] idx);
      case (idx)
         4'd0:                   req_state = WR_CLR;
         4'd1, 4'd2, 4'd3, 4'd4: req_state = WR_L1;
         4'd5:                   req_state = WR_ADDR;
         default:                req_state = WR_L2;
      endcase
   endfunction

   function automatic logic [19:0] add3(input logic [19:0] bcd);
      logic [19:0] r;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
      end
      add3 = r;
   endfunction

   assign init_mode = (state_q == INIT);
   assign last_byte = init_mode ? (idx_q == 4'd3) : (idx_q == 4'd11);
   assign wait_last = (!lcd_rs_q && lcd_data_q == 8'h01) ? CLR_LAST : CMD_LAST;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      opcode_d   = opcode_q;
      result_d   = result_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      lcd_data_d = lcd_data_q;
      lcd_rs_d   = lcd_rs_q;
      lcd_e_d    = lcd_e_q;
`ifdef LCD_SIGNED_EN
      neg_d      = neg_q;
`endif

      case (state_q)
         PWR_WAIT: begin
            if (cnt_q == PWR_LAST) begin
               state_d                = INIT;
               phase_d                = PH_SETUP;
               cnt_d                  = '0;
               idx_d                  = 4'd0;
               {lcd_rs_d, lcd_data_d} = byte_for(1'b1, 4'd0, opcode_q, bcd_q, sign_char);
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         IDLE: begin
            if (bus.start) begin
               state_d  = CONV;
               opcode_d = bus.opcode;
               result_d = bus.result;
               cnt_d    = '0;
            end
         end

         CONV: begin
            if (cnt_q == '0) begin
`ifdef LCD_SIGNED_EN
               neg_d = result_q[15];
               bin_d = result_q[15] ? (~result_q + 16'd1) : result_q;
`else
               bin_d = result_q;
`endif
               bcd_d = '0;
               cnt_d = CNT_ONE;
            end else begin
               // Correct-then-shift: no correction follows the final shift.
               bcd_d = {add3(bcd_q)[18:0], bin_q[15]};
               bin_d = {bin_q[14:0], 1'b0};
               if (cnt_q == CONV_LAST) begin
                  state_d                = WR_CLR;
                  phase_d                = PH_SETUP;
                  cnt_d                  = '0;
                  idx_d                  = 4'd0;
                  {lcd_rs_d, lcd_data_d} = byte_for(1'b0, 4'd0, opcode_q, bcd_q, sign_char);
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end

         default: begin
            case (phase_q)
               PH_SETUP: begin
                  phase_d = PH_PULSE;
                  cnt_d   = '0;
                  lcd_e_d = 1'b1;
               end
               PH_PULSE: begin
                  if (cnt_q == E_LAST) begin
                     phase_d = PH_WAIT;
                     cnt_d   = '0;
                     lcd_e_d = 1'b0;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end
               default: begin
                  if (cnt_q == wait_last) begin
                     phase_d = PH_SETUP;
                     cnt_d   = '0;
                     if (last_byte) begin
                        state_d = IDLE;
                     end else begin
                        idx_d                  = idx_q + 4'd1;
                        {lcd_rs_d, lcd_data_d} = byte_for(init_mode, idx_q + 4'd1,
                                                          opcode_q, bcd_q, sign_char);
                        if (!init_mode) begin
                           state_d = req_state(idx_q + 4'd1);
                        end
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PWR_WAIT;
         phase_q    <= PH_SETUP;
         cnt_q      <= '0;
         idx_q      <= '0;
         opcode_q   <= '0;
         result_q   <= '0;
         bin_q      <= '0;
         bcd_q      <= '0;
         lcd_data_q <= '0;
         lcd_rs_q   <= 1'b0;
         lcd_e_q    <= 1'b0;
`ifdef LCD_SIGNED_EN
         neg_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         opcode_q   <= opcode_d;
         result_q   <= result_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         lcd_data_q <= lcd_data_d;
         lcd_rs_q   <= lcd_rs_d;
         lcd_e_q    <= lcd_e_d;
`ifdef LCD_SIGNED_EN
         neg_q      <= neg_d;
`endif
      end
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.lcd_data = lcd_data_q;
   assign bus.lcd_rs   = lcd_rs_q;
   assign bus.lcd_rw   = 1'b0;
   assign bus.lcd_e    = lcd_e_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_result_writer.sv
`default_nettype none
// ============================================================================
// tb_lcd_result_writer : directed bench for lcd_result_writer (small timing params)
// Rev 1.0
// ============================================================================
module tb_lcd_result_writer;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;
   int   n;
   logic e_prev;
   logic [8:0] got [$];

   lcd_result_writer_if bus ();

   lcd_result_writer #(
      .E_CYCLES     (2),
      .CMD_WAIT     (4),
      .CLEAR_WAIT   (8),
      .POWERUP_WAIT (10)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records {rs, data} at every rising edge of lcd_e.
   always @(negedge clk) begin
      if (bus.lcd_e === 1'b1 && e_prev !== 1'b1) got.push_back({bus.lcd_rs, bus.lcd_data});
      e_prev = bus.lcd_e;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic wait_not_busy(output int cycles);
      cycles = 0;
      while (bus.busy === 1'b1 && cycles < 2000) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic request(input logic [2:0] op, input logic [15:0] res);
      @(negedge clk);
      bus.opcode = op;
      bus.result = res;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("busy after accept", bus.busy, 1);
   endtask

   task automatic check_init(input string tag);
      logic [8:0] exp [4];
      exp[0] = 9'h038; exp[1] = 9'h00C; exp[2] = 9'h006; exp[3] = 9'h001;
      check({tag, " byte count"}, got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++)
         check($sformatf("%s byte%0d", tag, i), got[i], exp[i]);
   endtask

   task automatic check_req(input string tag, input logic [31:0] l1, input logic [47:0] l2);
      logic [8:0] exp [12];
      exp[0] = 9'h001;
      for (int i = 0; i < 4; i++) exp[1 + i] = {1'b1, l1[31 - 8*i -: 8]};
      exp[5] = 9'h0C0;
      for (int i = 0; i < 6; i++) exp[6 + i] = {1'b1, l2[47 - 8*i -: 8]};
      check({tag, " byte count"}, got.size(), 12);
      for (int i = 0; i < 12 && i < got.size(); i++)
         check($sformatf("%s byte%0d", tag, i), got[i], exp[i]);
   endtask

   initial begin
      pass_cnt   = 0;
      total_cnt  = 0;
      e_prev     = 1'b0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.opcode = 3'd0;
      bus.result = 16'd0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", bus.busy, 1);
      check("reset lcd_e", bus.lcd_e, 0);
      check("reset lcd_rs", bus.lcd_rs, 0);
      check("reset lcd_rw", bus.lcd_rw, 0);
      check("reset lcd_data", bus.lcd_data, 0);

      // Power-on init
      @(negedge clk);
      rst_n = 1'b1;
      got.delete();
      wait_not_busy(n);
      check("init busy cycles", n, 42);
      check_init("init");

      // ADD 0x0123 = 291
      got.delete();
      request(3'b001, 16'h0123);
      wait_not_busy(n);
      check("req busy cycles", n, 105);
`ifdef LCD_SIGNED_EN
      check_req("add291", "ADD ", "+00291");
`else
      check_req("add291", "ADD ", " 00291");
`endif
      check("lcd_data held", bus.lcd_data, 8'h31);
      check("lcd_rs held", bus.lcd_rs, 1);

      // SUB 0xFFFF
      got.delete();
      request(3'b011, 16'hFFFF);
      wait_not_busy(n);
`ifdef LCD_SIGNED_EN
      check_req("subffff", "SUB ", "-00001");
`else
      check_req("subffff", "SUB ", " 65535");
`endif

      // DISP 0x8000
      got.delete();
      request(3'b111, 16'h8000);
      wait_not_busy(n);
`ifdef LCD_SIGNED_EN
      check_req("disp8000", "DISP", "-32768");
`else
      check_req("disp8000", "DISP", " 32768");
`endif

      // LOAD 0 with a second start pulse 20 cycles in: dropped
      got.delete();
      request(3'b000, 16'h0000);
      repeat (19) @(posedge clk);
      @(negedge clk);
      bus.opcode = 3'b101;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_not_busy(n);
`ifdef LCD_SIGNED_EN
      check_req("load0", "LOAD", "+00000");
`else
      check_req("load0", "LOAD", " 00000");
`endif
      repeat (5) @(posedge clk);
      #1;
      check("no queued request busy", bus.busy, 0);
      check("no queued request bytes", got.size(), 12);

      // start held high: back-to-back requests, one IDLE cycle apart
      got.delete();
      @(negedge clk);
      bus.opcode = 3'b101;
      bus.result = 16'd12345;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      check("held accept busy", bus.busy, 1);
      wait_not_busy(n);
      check("held first busy cycles", n, 105);
      @(posedge clk);
      #1;
      check("held re-accept after 1 idle", bus.busy, 1);
      bus.start = 1'b0;
      wait_not_busy(n);
      check("held total bytes", got.size(), 24);
`ifdef LCD_SIGNED_EN
      check("held sign", (got.size() > 6) ? got[6] : 9'h000, {1'b1, 8'h2B});
`else
      check("held sign", (got.size() > 6) ? got[6] : 9'h000, {1'b1, 8'h20});
`endif
      check("held last digit", (got.size() > 23) ? got[23] : 9'h000, {1'b1, 8'h35});

      // Reset during WR_L1: outputs clear without a clock edge, init repeats
      request(3'b110, 16'd7);
      repeat (30) @(posedge clk);
      #1;
      check("pre-reset lcd_e", bus.lcd_e, 1);
      check("pre-reset lcd_data", bus.lcd_data, 8'h43);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset lcd_e", bus.lcd_e, 0);
      check("async reset lcd_rs", bus.lcd_rs, 0);
      check("async reset lcd_data", bus.lcd_data, 0);
      check("async reset busy", bus.busy, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      got.delete();
      wait_not_busy(n);
      check("reinit busy cycles", n, 42);
      check_init("reinit");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
